// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit signal bundle: ID/EXE/memory status in, pipeline enables and flushes out.
// The master modport is the pipeline side that drives status; the slave is the hazard unit.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_csr;
    logic        exe_memread;
    logic [4:0]  exe_write_addr;
    logic        exe_branch_taken;
    logic        trap_req;
    logic        im_stall;
    logic        dm_stall;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        control_flush;
    logic        csr_stall;
    logic        csr_reset;
    logic        trap_pc_sel;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2, id_csr,
               exe_memread, exe_write_addr, exe_branch_taken, trap_req,
               im_stall, dm_stall,
        input  pc_write, ifid_write, ifid_flush, control_flush, csr_stall,
               csr_reset, trap_pc_sel, stall_cycles
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2, id_csr,
               exe_memread, exe_write_addr, exe_branch_taken, trap_req,
               im_stall, dm_stall,
        output pc_write, ifid_write, ifid_flush, control_flush, csr_stall,
               csr_reset, trap_pc_sel, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, CSR drain sequencing,
// one-cycle trap flush, and a saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl #(
    parameter int unsigned CSR_DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CSR_DRAIN = 2'd1,
        TRAP      = 2'd2
    } state_t;

    // The RUN cycle that detects the CSR is itself the first bubble.
    localparam logic [3:0] CNT_LOAD = 4'(CSR_DRAIN_CYCLES - 32'd2);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        csr_done_r;
    logic        csr_done_s;
    logic [15:0] stall_cycles_r;

    logic        mem_stall_s;
    logic        load_use_s;
    logic        pc_write_s;
    logic        ifid_write_s;
    logic        ifid_flush_s;
    logic        control_flush_s;
    logic        csr_stall_s;

    assign mem_stall_s = hz.im_stall | hz.dm_stall;
    assign load_use_s  = hz.exe_memread & (hz.exe_write_addr != 5'd0) &
                         ((hz.id_use_rs1 & (hz.id_rs1_addr == hz.exe_write_addr)) |
                          (hz.id_use_rs2 & (hz.id_rs2_addr == hz.exe_write_addr)));

    // State, drain counter, CSR-done flag and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= RUN;
            cnt_r          <= 4'd0;
            csr_done_r     <= 1'b0;
            stall_cycles_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            csr_done_r <= csr_done_s;
            if (!pc_write_s && (stall_cycles_r != 16'hFFFF)) begin
                stall_cycles_r <= stall_cycles_r + 16'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    // Next-state and pipeline-control decode.
    always_comb begin
        state_s         = state_r;
        cnt_s           = cnt_r;
        csr_done_s      = csr_done_r;
        pc_write_s      = 1'b0;
        ifid_write_s    = 1'b0;
        ifid_flush_s    = 1'b0;
        control_flush_s = 1'b0;
        csr_stall_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_s = state_r;
                end else if (hz.trap_req) begin
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    state_s      = TRAP;
                end else if (hz.exe_branch_taken) begin
                    pc_write_s      = 1'b1;
                    ifid_write_s    = 1'b1;
                    ifid_flush_s    = 1'b1;
                    control_flush_s = 1'b1;
                    csr_done_s      = 1'b0;
                end else if (load_use_s) begin
                    control_flush_s = 1'b1;
                end else if (hz.id_csr && !csr_done_r) begin
                    csr_stall_s = 1'b1;
                    cnt_s       = CNT_LOAD;
                    state_s     = CSR_DRAIN;
                end else begin
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    csr_done_s   = 1'b0;
                end
            end
            CSR_DRAIN: begin
                if (mem_stall_s) begin
                    state_s = state_r;
                end else if (hz.trap_req) begin
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    csr_done_s   = 1'b0;
                    state_s      = TRAP;
                end else if (hz.exe_branch_taken) begin
                    pc_write_s      = 1'b1;
                    ifid_write_s    = 1'b1;
                    ifid_flush_s    = 1'b1;
                    control_flush_s = 1'b1;
                    csr_done_s      = 1'b0;
                    state_s         = RUN;
                end else begin
                    csr_stall_s = 1'b1;
                    if (cnt_r == 4'd0) begin
                        csr_done_s = 1'b1;
                        state_s    = RUN;
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end
            end
            TRAP: begin
                // Trap flush proceeds even under a memory wait.
                pc_write_s      = 1'b1;
                ifid_write_s    = 1'b1;
                ifid_flush_s    = 1'b1;
                control_flush_s = 1'b1;
                csr_done_s      = 1'b0;
                state_s         = RUN;
            end
            default: begin
                state_s    = RUN;
                cnt_s      = 4'd0;
                csr_done_s = 1'b0;
            end
        endcase
    end

    assign hz.pc_write      = pc_write_s;
    assign hz.ifid_write    = ifid_write_s;
    assign hz.ifid_flush    = ifid_flush_s;
    assign hz.control_flush = control_flush_s;
    assign hz.csr_stall     = csr_stall_s;
    assign hz.csr_reset     = (state_r == TRAP);
    assign hz.trap_pc_sel   = (state_r == TRAP);
    assign hz.stall_cycles  = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues its expected
// control outputs and stall count; a monitor pops and compares before the next edge.
module tb_pipeline_hazard_ctrl;

    // ctl bits: {use_rs1, use_rs2, csr, memread, branch, trap, im_stall, dm_stall}
    localparam logic [7:0] U1  = 8'h80;
    localparam logic [7:0] U2  = 8'h40;
    localparam logic [7:0] CSR = 8'h20;
    localparam logic [7:0] MR  = 8'h10;
    localparam logic [7:0] BR  = 8'h08;
    localparam logic [7:0] TR  = 8'h04;
    localparam logic [7:0] IMS = 8'h02;
    localparam logic [7:0] DMS = 8'h01;

    // outs: {pc_write, ifid_write, ifid_flush, control_flush, csr_stall, csr_reset, trap_pc_sel}
    localparam logic [6:0] E_RUN  = 7'b1100000;
    localparam logic [6:0] E_LU   = 7'b0001000;
    localparam logic [6:0] E_BR   = 7'b1111000;
    localparam logic [6:0] E_CSR  = 7'b0000100;
    localparam logic [6:0] E_MS   = 7'b0000000;
    localparam logic [6:0] E_TRAP = 7'b1111011;
    localparam logic [6:0] M_ALL  = 7'b1111111;
    localparam logic [6:0] M_TRAP = 7'b1011111;

    typedef struct {
        logic [6:0]  e;
        logic [6:0]  m;
        logic [15:0] st;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        rst_lvl;
    logic [15:0] exp_stall;
    int          n_vec;
    int          n_miss;
    sb_t         sb[$];
    sb_t         ent;
    logic [6:0]  obs;

    pipeline_hazard_ctrl_if hif();

    pipeline_hazard_ctrl #(.CSR_DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    task automatic step(input logic [7:0] ctl, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] wa, input logic [6:0] e, input logic [6:0] m = M_ALL);
        sb_t s;
        @(negedge clk);
        reset                = rst_lvl;
        hif.id_use_rs1       = ctl[7];
        hif.id_use_rs2       = ctl[6];
        hif.id_csr           = ctl[5];
        hif.exe_memread      = ctl[4];
        hif.exe_branch_taken = ctl[3];
        hif.trap_req         = ctl[2];
        hif.im_stall         = ctl[1];
        hif.dm_stall         = ctl[0];
        hif.id_rs1_addr      = rs1;
        hif.id_rs2_addr      = rs2;
        hif.exe_write_addr   = wa;
        if (!rst_lvl) exp_stall = 16'd0;
        s.e  = e;
        s.m  = m;
        s.st = exp_stall;
        sb.push_back(s);
        if (rst_lvl && !e[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic stepc(input logic [7:0] ctl, input logic [6:0] e, input logic [6:0] m = M_ALL);
        step(ctl, 5'd0, 5'd0, 5'd0, e, m);
    endtask

    // Monitor: compare queued expectations a few ns after each driving edge.
    always @(negedge clk) begin
        #3;
        if (sb.size() > 0) begin
            ent = sb.pop_front();
            obs = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.control_flush,
                   hif.csr_stall, hif.csr_reset, hif.trap_pc_sel};
            check_val("outs", 32'(obs & ent.m), 32'(ent.e & ent.m));
            check_val("stall_cycles", 32'(hif.stall_cycles), 32'(ent.st));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_miss = 0; exp_stall = 16'd0;
        rst_lvl = 1'b0; reset = 1'b0;
        hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0; hif.id_csr = 1'b0;
        hif.exe_memread = 1'b0; hif.exe_branch_taken = 1'b0; hif.trap_req = 1'b0;
        hif.im_stall = 1'b0; hif.dm_stall = 1'b0;
        hif.id_rs1_addr = 5'd0; hif.id_rs2_addr = 5'd0; hif.exe_write_addr = 5'd0;

        stepc(8'h00, E_RUN);
        stepc(8'h00, E_RUN);
        rst_lvl = 1'b1;
        stepc(8'h00, E_RUN);

        // Load-use on rs2, then x0 destination, rs1 match, no-use.
        step(MR | U2, 5'd0, 5'd5, 5'd5, E_LU);
        stepc(8'h00, E_RUN);
        step(MR | U2, 5'd0, 5'd0, 5'd0, E_RUN);
        step(MR | U1, 5'd7, 5'd0, 5'd7, E_LU);
        step(MR, 5'd7, 5'd7, 5'd7, E_RUN);
        step(MR | U1, 5'd3, 5'd0, 5'd3, E_LU);
        step(MR | U1, 5'd3, 5'd0, 5'd3, E_LU);

        // Branch beats load-use.
        step(MR | U2 | BR, 5'd0, 5'd5, 5'd5, E_BR);

        // CSR drain: three bubbles then release.
        stepc(CSR, E_CSR); stepc(CSR, E_CSR); stepc(CSR, E_CSR);
        stepc(CSR, E_RUN);
        stepc(8'h00, E_RUN);

        // CSR drain stretched by a two-cycle data-memory wait.
        stepc(CSR, E_CSR);
        stepc(CSR | DMS, E_MS); stepc(CSR | DMS, E_MS);
        stepc(CSR, E_CSR); stepc(CSR, E_CSR);
        stepc(CSR, E_RUN);
        stepc(8'h00, E_RUN);

        // Load-use outranks a pending CSR.
        step(MR | U1 | CSR, 5'd3, 5'd0, 5'd3, E_LU);
        stepc(CSR, E_CSR); stepc(CSR, E_CSR); stepc(CSR, E_CSR);
        stepc(CSR, E_RUN);
        stepc(8'h00, E_RUN);

        // Trap in RUN, trap delayed by instruction-memory wait, trap ignoring mem wait.
        stepc(TR, E_RUN); stepc(TR, E_TRAP, M_TRAP); stepc(8'h00, E_RUN);
        stepc(TR | IMS, E_MS); stepc(TR | IMS, E_MS);
        stepc(TR, E_RUN); stepc(TR, E_TRAP, M_TRAP); stepc(8'h00, E_RUN);
        stepc(TR, E_RUN); stepc(TR | DMS, E_TRAP, M_TRAP); stepc(8'h00, E_RUN);

        // Trap outranks branch.
        stepc(TR | BR, E_RUN); stepc(TR, E_TRAP, M_TRAP); stepc(8'h00, E_RUN);

        // Branch during drain returns to RUN.
        stepc(CSR, E_CSR); stepc(CSR | BR, E_BR); stepc(8'h00, E_RUN);

        // Reset mid-drain, then a held CSR restarts the full drain.
        stepc(CSR, E_CSR); stepc(CSR, E_CSR);
        rst_lvl = 1'b0;
        stepc(8'h00, E_RUN);
        rst_lvl = 1'b1;
        stepc(CSR, E_CSR); stepc(CSR, E_CSR); stepc(CSR, E_CSR);
        stepc(CSR, E_RUN);
        stepc(8'h00, E_RUN);

        // Reset while in TRAP: no pulse.
        stepc(TR, E_RUN);
        rst_lvl = 1'b0;
        stepc(TR, E_RUN);
        rst_lvl = 1'b1;
        stepc(8'h00, E_RUN);

        repeat (2) @(negedge clk);
        #5;
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
